ym2413_reg_file: RTL and testbench

//   Host-side register file for the YM2413/VRC7 core. Decodes CPU address/data port writes,

---
 rtl/ym2413_reg_file.sv | 207 ++++++++++++++++++++
 tb/tb_ym2413_reg_file.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ym2413_reg_file.sv
// rtl/ym2413_reg_file.sv - YM2413/VRC7 host register file with post-write busy windows.
// Optional YM2413_RHYTHM_EN decodes rhythm control at $0E; otherwise rhythm outputs are tied 0.
module ym2413_reg_file #(
  parameter int ADDR_WAIT = 12,
  parameter int DATA_WAIT = 84
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cpu_we,
  input  logic       cpu_a0,
  input  logic [7:0] cpu_d,
  output logic       busy,
  output logic       r_ut_op0_am,
  output logic       r_ut_op0_vib,
  output logic       r_ut_op0_egtyp,
  output logic       r_ut_op0_ksr,
  output logic [3:0] r_ut_op0_mult,
  output logic [1:0] r_ut_op0_ksl,
  output logic [5:0] r_ut_op0_tl,
  output logic       r_ut_op0_wf,
  output logic [2:0] r_ut_op0_fb,
  output logic [3:0] r_ut_op0_ar,
  output logic [3:0] r_ut_op0_dr,
  output logic [3:0] r_ut_op0_sl,
  output logic [3:0] r_ut_op0_rr,
  output logic       r_ut_op1_am,
  output logic       r_ut_op1_vib,
  output logic       r_ut_op1_egtyp,
  output logic       r_ut_op1_ksr,
  output logic [3:0] r_ut_op1_mult,
  output logic [1:0] r_ut_op1_ksl,
  output logic       r_ut_op1_wf,
  output logic [3:0] r_ut_op1_ar,
  output logic [3:0] r_ut_op1_dr,
  output logic [3:0] r_ut_op1_sl,
  output logic [3:0] r_ut_op1_rr,
  output logic [8:0] r_ch0_fnum, r_ch1_fnum, r_ch2_fnum, r_ch3_fnum, r_ch4_fnum,
  output logic [8:0] r_ch5_fnum, r_ch6_fnum, r_ch7_fnum, r_ch8_fnum,
  output logic [2:0] r_ch0_block, r_ch1_block, r_ch2_block, r_ch3_block, r_ch4_block,
  output logic [2:0] r_ch5_block, r_ch6_block, r_ch7_block, r_ch8_block,
  output logic       r_ch0_sust_on, r_ch1_sust_on, r_ch2_sust_on, r_ch3_sust_on, r_ch4_sust_on,
  output logic       r_ch5_sust_on, r_ch6_sust_on, r_ch7_sust_on, r_ch8_sust_on,
  output logic       r_ch0_key_on, r_ch1_key_on, r_ch2_key_on, r_ch3_key_on, r_ch4_key_on,
  output logic       r_ch5_key_on, r_ch6_key_on, r_ch7_key_on, r_ch8_key_on,
  output logic [3:0] r_ch0_inst_nr, r_ch1_inst_nr, r_ch2_inst_nr, r_ch3_inst_nr, r_ch4_inst_nr,
  output logic [3:0] r_ch5_inst_nr, r_ch6_inst_nr, r_ch7_inst_nr, r_ch8_inst_nr,
  output logic [3:0] r_ch0_vol, r_ch1_vol, r_ch2_vol, r_ch3_vol, r_ch4_vol,
  output logic [3:0] r_ch5_vol, r_ch6_vol, r_ch7_vol, r_ch8_vol,
  output logic       r_ch_rhy_en,
  output logic       r_ch_rhy_bd_on,
  output logic       r_ch_rhy_sd_on,
  output logic       r_ch_rhy_tom_on,
  output logic       r_ch_rhy_cym_on,
  output logic       r_ch_rhy_hh_on
);

  logic [7:0] addr_lat;
  logic [6:0] busy_cnt;
  logic       data_wr;

  logic [7:0] op0_mode, op1_mode, op0_env_a, op1_env_a, op0_env_s, op1_env_s;
  logic [7:0] op0_level;
  logic [1:0] op1_ksl_q;
  logic       op1_wf_q, op0_wf_q;
  logic [2:0] op0_fb_q;

  logic [8:0] fnum  [9];
  logic [2:0] block [9];
  logic [8:0] sust, key;
  logic [3:0] inst  [9];
  logic [3:0] vol   [9];

  assign busy    = (busy_cnt != 7'd0);
  assign data_wr = cpu_we && cpu_a0 && !busy;

  // Writes arriving while busy are discarded outright, including the counter reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_lat <= 8'h00;
      busy_cnt <= 7'd0;
    end else if (cpu_we && !busy) begin
      if (!cpu_a0) begin
        addr_lat <= cpu_d;
        busy_cnt <= 7'(ADDR_WAIT);
      end else begin
        busy_cnt <= 7'(DATA_WAIT);
      end
    end else if (busy_cnt != 7'd0) begin
      busy_cnt <= busy_cnt - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op0_mode  <= 8'h00;
      op1_mode  <= 8'h00;
      op0_level <= 8'h00;
      op1_ksl_q <= 2'b00;
      op1_wf_q  <= 1'b0;
      op0_wf_q  <= 1'b0;
      op0_fb_q  <= 3'b000;
      op0_env_a <= 8'h00;
      op1_env_a <= 8'h00;
      op0_env_s <= 8'h00;
      op1_env_s <= 8'h00;
    end else if (data_wr) begin
      case (addr_lat)
        8'h00: op0_mode  <= cpu_d;
        8'h01: op1_mode  <= cpu_d;
        8'h02: op0_level <= cpu_d;
        8'h03: begin
          op1_ksl_q <= cpu_d[7:6];
          op1_wf_q  <= cpu_d[4];
          op0_wf_q  <= cpu_d[3];
          op0_fb_q  <= cpu_d[2:0];
        end
        8'h04: op0_env_a <= cpu_d;
        8'h05: op1_env_a <= cpu_d;
        8'h06: op0_env_s <= cpu_d;
        8'h07: op1_env_s <= cpu_d;
        default: ;
      endcase
    end
  end

  // Full 8-bit compare per channel so $50, $90 etc. never alias onto $10.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 9; n++) begin
        fnum[n]  <= 9'd0;
        block[n] <= 3'd0;
        inst[n]  <= 4'd0;
        vol[n]   <= 4'd0;
      end
      sust <= 9'd0;
      key  <= 9'd0;
    end else if (data_wr) begin
      for (int n = 0; n < 9; n++) begin
        if (addr_lat == (8'h10 | 8'(n))) begin
          fnum[n][7:0] <= cpu_d;
        end
        if (addr_lat == (8'h20 | 8'(n))) begin
          sust[n]    <= cpu_d[5];
          key[n]     <= cpu_d[4];
          block[n]   <= cpu_d[3:1];
          fnum[n][8] <= cpu_d[0];
        end
        if (addr_lat == (8'h30 | 8'(n))) begin
          inst[n] <= cpu_d[7:4];
          vol[n]  <= cpu_d[3:0];
        end
      end
    end
  end

`ifdef YM2413_RHYTHM_EN
  logic [5:0] rhy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rhy_q <= 6'd0;
    end else if (data_wr && addr_lat == 8'h0E) begin
      rhy_q <= cpu_d[5:0];
    end
  end

  assign {r_ch_rhy_en, r_ch_rhy_bd_on, r_ch_rhy_sd_on,
          r_ch_rhy_tom_on, r_ch_rhy_cym_on, r_ch_rhy_hh_on} = rhy_q;
`else
  assign {r_ch_rhy_en, r_ch_rhy_bd_on, r_ch_rhy_sd_on,
          r_ch_rhy_tom_on, r_ch_rhy_cym_on, r_ch_rhy_hh_on} = 6'd0;
`endif

  assign {r_ut_op0_am, r_ut_op0_vib, r_ut_op0_egtyp, r_ut_op0_ksr, r_ut_op0_mult} = op0_mode;
  assign {r_ut_op1_am, r_ut_op1_vib, r_ut_op1_egtyp, r_ut_op1_ksr, r_ut_op1_mult} = op1_mode;
  assign {r_ut_op0_ksl, r_ut_op0_tl} = op0_level;
  assign r_ut_op1_ksl = op1_ksl_q;
  assign r_ut_op1_wf  = op1_wf_q;
  assign r_ut_op0_wf  = op0_wf_q;
  assign r_ut_op0_fb  = op0_fb_q;
  assign {r_ut_op0_ar, r_ut_op0_dr} = op0_env_a;
  assign {r_ut_op1_ar, r_ut_op1_dr} = op1_env_a;
  assign {r_ut_op0_sl, r_ut_op0_rr} = op0_env_s;
  assign {r_ut_op1_sl, r_ut_op1_rr} = op1_env_s;

  assign r_ch0_fnum = fnum[0];  assign r_ch1_fnum = fnum[1];  assign r_ch2_fnum = fnum[2];
  assign r_ch3_fnum = fnum[3];  assign r_ch4_fnum = fnum[4];  assign r_ch5_fnum = fnum[5];
  assign r_ch6_fnum = fnum[6];  assign r_ch7_fnum = fnum[7];  assign r_ch8_fnum = fnum[8];

  assign r_ch0_block = block[0];  assign r_ch1_block = block[1];  assign r_ch2_block = block[2];
  assign r_ch3_block = block[3];  assign r_ch4_block = block[4];  assign r_ch5_block = block[5];
  assign r_ch6_block = block[6];  assign r_ch7_block = block[7];  assign r_ch8_block = block[8];

  assign {r_ch8_sust_on, r_ch7_sust_on, r_ch6_sust_on, r_ch5_sust_on, r_ch4_sust_on,
          r_ch3_sust_on, r_ch2_sust_on, r_ch1_sust_on, r_ch0_sust_on} = sust;
  assign {r_ch8_key_on, r_ch7_key_on, r_ch6_key_on, r_ch5_key_on, r_ch4_key_on,
          r_ch3_key_on, r_ch2_key_on, r_ch1_key_on, r_ch0_key_on} = key;

  assign r_ch0_inst_nr = inst[0];  assign r_ch1_inst_nr = inst[1];  assign r_ch2_inst_nr = inst[2];
  assign r_ch3_inst_nr = inst[3];  assign r_ch4_inst_nr = inst[4];  assign r_ch5_inst_nr = inst[5];
  assign r_ch6_inst_nr = inst[6];  assign r_ch7_inst_nr = inst[7];  assign r_ch8_inst_nr = inst[8];

  assign r_ch0_vol = vol[0];  assign r_ch1_vol = vol[1];  assign r_ch2_vol = vol[2];
  assign r_ch3_vol = vol[3];  assign r_ch4_vol = vol[4];  assign r_ch5_vol = vol[5];
  assign r_ch6_vol = vol[6];  assign r_ch7_vol = vol[7];  assign r_ch8_vol = vol[8];

endmodule

// File: tb/tb_ym2413_reg_file.sv
// tb/tb_ym2413_reg_file.sv - randomized self-checking bench for ym2413_reg_file.
// Reference model: a byte image of every data write, decoded into expected fields.
module tb_ym2413_reg_file;

  localparam int ADDR_WAIT = 12;
  localparam int DATA_WAIT = 84;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_we = 1'b0;
  logic       cpu_a0 = 1'b0;
  logic [7:0] cpu_d = 8'h00;
  logic       busy;

  logic       op0_am, op0_vib, op0_egtyp, op0_ksr, op0_wf;
  logic [3:0] op0_mult, op0_ar, op0_dr, op0_sl, op0_rr;
  logic [1:0] op0_ksl;
  logic [5:0] op0_tl;
  logic [2:0] op0_fb;
  logic       op1_am, op1_vib, op1_egtyp, op1_ksr, op1_wf;
  logic [3:0] op1_mult, op1_ar, op1_dr, op1_sl, op1_rr;
  logic [1:0] op1_ksl;

  logic [8:0][8:0] b_fnum;
  logic [8:0][2:0] b_block;
  logic [8:0]      b_sust, b_key;
  logic [8:0][3:0] b_inst, b_vol;
  logic            rhy_en, rhy_bd, rhy_sd, rhy_tom, rhy_cym, rhy_hh;

  logic [197:0] dut_ch;
  logic [266:0] dut_vec;

  logic [7:0] mem [256];
  logic [7:0] lat;
  int         bcnt;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  ym2413_reg_file #(.ADDR_WAIT(ADDR_WAIT), .DATA_WAIT(DATA_WAIT)) dut (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_a0(cpu_a0), .cpu_d(cpu_d), .busy(busy),
    .r_ut_op0_am(op0_am), .r_ut_op0_vib(op0_vib), .r_ut_op0_egtyp(op0_egtyp), .r_ut_op0_ksr(op0_ksr),
    .r_ut_op0_mult(op0_mult), .r_ut_op0_ksl(op0_ksl), .r_ut_op0_tl(op0_tl), .r_ut_op0_wf(op0_wf),
    .r_ut_op0_fb(op0_fb), .r_ut_op0_ar(op0_ar), .r_ut_op0_dr(op0_dr), .r_ut_op0_sl(op0_sl),
    .r_ut_op0_rr(op0_rr),
    .r_ut_op1_am(op1_am), .r_ut_op1_vib(op1_vib), .r_ut_op1_egtyp(op1_egtyp), .r_ut_op1_ksr(op1_ksr),
    .r_ut_op1_mult(op1_mult), .r_ut_op1_ksl(op1_ksl), .r_ut_op1_wf(op1_wf), .r_ut_op1_ar(op1_ar),
    .r_ut_op1_dr(op1_dr), .r_ut_op1_sl(op1_sl), .r_ut_op1_rr(op1_rr),
    .r_ch0_fnum(b_fnum[0]), .r_ch1_fnum(b_fnum[1]), .r_ch2_fnum(b_fnum[2]), .r_ch3_fnum(b_fnum[3]),
    .r_ch4_fnum(b_fnum[4]), .r_ch5_fnum(b_fnum[5]), .r_ch6_fnum(b_fnum[6]), .r_ch7_fnum(b_fnum[7]),
    .r_ch8_fnum(b_fnum[8]),
    .r_ch0_block(b_block[0]), .r_ch1_block(b_block[1]), .r_ch2_block(b_block[2]), .r_ch3_block(b_block[3]),
    .r_ch4_block(b_block[4]), .r_ch5_block(b_block[5]), .r_ch6_block(b_block[6]), .r_ch7_block(b_block[7]),
    .r_ch8_block(b_block[8]),
    .r_ch0_sust_on(b_sust[0]), .r_ch1_sust_on(b_sust[1]), .r_ch2_sust_on(b_sust[2]), .r_ch3_sust_on(b_sust[3]),
    .r_ch4_sust_on(b_sust[4]), .r_ch5_sust_on(b_sust[5]), .r_ch6_sust_on(b_sust[6]), .r_ch7_sust_on(b_sust[7]),
    .r_ch8_sust_on(b_sust[8]),
    .r_ch0_key_on(b_key[0]), .r_ch1_key_on(b_key[1]), .r_ch2_key_on(b_key[2]), .r_ch3_key_on(b_key[3]),
    .r_ch4_key_on(b_key[4]), .r_ch5_key_on(b_key[5]), .r_ch6_key_on(b_key[6]), .r_ch7_key_on(b_key[7]),
    .r_ch8_key_on(b_key[8]),
    .r_ch0_inst_nr(b_inst[0]), .r_ch1_inst_nr(b_inst[1]), .r_ch2_inst_nr(b_inst[2]), .r_ch3_inst_nr(b_inst[3]),
    .r_ch4_inst_nr(b_inst[4]), .r_ch5_inst_nr(b_inst[5]), .r_ch6_inst_nr(b_inst[6]), .r_ch7_inst_nr(b_inst[7]),
    .r_ch8_inst_nr(b_inst[8]),
    .r_ch0_vol(b_vol[0]), .r_ch1_vol(b_vol[1]), .r_ch2_vol(b_vol[2]), .r_ch3_vol(b_vol[3]),
    .r_ch4_vol(b_vol[4]), .r_ch5_vol(b_vol[5]), .r_ch6_vol(b_vol[6]), .r_ch7_vol(b_vol[7]),
    .r_ch8_vol(b_vol[8]),
    .r_ch_rhy_en(rhy_en), .r_ch_rhy_bd_on(rhy_bd), .r_ch_rhy_sd_on(rhy_sd),
    .r_ch_rhy_tom_on(rhy_tom), .r_ch_rhy_cym_on(rhy_cym), .r_ch_rhy_hh_on(rhy_hh)
  );

  always_comb begin
    dut_ch = '0;
    for (int n = 0; n < 9; n++)
      dut_ch[n*22 +: 22] = {b_fnum[n], b_block[n], b_sust[n], b_key[n], b_inst[n], b_vol[n]};
  end

  assign dut_vec = {dut_ch,
                    op0_am, op0_vib, op0_egtyp, op0_ksr, op0_mult, op0_ksl, op0_tl, op0_wf, op0_fb,
                    op0_ar, op0_dr, op0_sl, op0_rr,
                    op1_am, op1_vib, op1_egtyp, op1_ksr, op1_mult, op1_ksl, op1_wf,
                    op1_ar, op1_dr, op1_sl, op1_rr,
                    rhy_en, rhy_bd, rhy_sd, rhy_tom, rhy_cym, rhy_hh};

  // Expected outputs straight from the last byte written to each register address.
  function automatic logic [266:0] exp_vec();
    logic [197:0] ch;
    logic [35:0]  p0;
    logic [26:0]  p1;
    logic [5:0]   rh;
    for (int n = 0; n < 9; n++)
      ch[n*22 +: 22] = {mem[8'h20 + n][0], mem[8'h10 + n], mem[8'h20 + n][3:1],
                        mem[8'h20 + n][5], mem[8'h20 + n][4], mem[8'h30 + n]};
    p0 = {mem[0], mem[2], mem[3][3], mem[3][2:0], mem[4], mem[6]};
    p1 = {mem[1], mem[3][7:6], mem[3][4], mem[5], mem[7]};
`ifdef YM2413_RHYTHM_EN
    rh = mem[8'h0E][5:0];
`else
    rh = 6'd0;
`endif
    return {ch, p0, p1, rh};
  endfunction

  // One clock: drive, let the edge happen, advance the model, return at the falling edge.
  task automatic cycle(input logic we, input logic a0, input logic [7:0] d, input logic r);
    cpu_we = we; cpu_a0 = a0; cpu_d = d; rst = r;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      lat = 8'h00;
      bcnt = 0;
    end else if (we && bcnt == 0) begin
      if (a0) begin
        mem[lat] = d;
        bcnt = DATA_WAIT;
      end else begin
        lat = d;
        bcnt = ADDR_WAIT;
      end
    end else if (bcnt > 0) begin
      bcnt--;
    end
    @(negedge clk);
    cpu_we = 1'b0; rst = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && bcnt != 0; i++) cycle(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b0, 8'h00, 1'b1);
    total++;
    if (dut_vec !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", dut_vec); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    cycle(1'b1, 1'b0, 8'h10, 1'b0);
    drain();
    cycle(1'b1, 1'b1, 8'h5A, 1'b0);
    total++;
    if (b_fnum[0] !== 9'h05A) begin bad++; $display("FAIL ch0_fnum got=%h exp=05a", b_fnum[0]); end
    drain();
  endtask

  task automatic test_block_key();
    int n;
    cycle(1'b1, 1'b0, 8'h21, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; cycle(1'b0, 1'b0, 8'h00, 1'b0); end
    total++;
    if (n != ADDR_WAIT) begin bad++; $display("FAIL addr_busy_len got=%0d exp=%0d", n, ADDR_WAIT); end
    cycle(1'b1, 1'b1, 8'h1F, 1'b0);
    total++;
    if ({b_sust[1], b_key[1], b_block[1], b_fnum[1][8]} !== 6'b0_1_111_1) begin
      bad++; $display("FAIL ch1_ctl got=%b exp=011111", {b_sust[1], b_key[1], b_block[1], b_fnum[1][8]});
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; cycle(1'b0, 1'b0, 8'h00, 1'b0); end
    total++;
    if (n != DATA_WAIT) begin bad++; $display("FAIL data_busy_len got=%0d exp=%0d", n, DATA_WAIT); end
    drain();
  endtask

  task automatic test_dropped_write();
    int n;
    cycle(1'b1, 1'b0, 8'h30, 1'b0);
    cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    total++;
    if ({b_inst[0], b_vol[0]} !== 8'h00) begin bad++; $display("FAIL drop_ch0 got=%h exp=00", {b_inst[0], b_vol[0]}); end
    n = 0;
    while (busy === 1'b1 && n < 200) begin n++; cycle(1'b0, 1'b0, 8'h00, 1'b0); end
    total++;
    if (n != ADDR_WAIT - 1) begin bad++; $display("FAIL drop_busy_left got=%0d exp=%0d", n, ADDR_WAIT - 1); end
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL drop_vec got=%h exp=%h", dut_vec, exp_vec()); end
    drain();
  endtask

  task automatic test_patch_and_noop();
    logic [266:0] snap;
    cycle(1'b1, 1'b0, 8'h03, 1'b0);
    drain();
    cycle(1'b1, 1'b1, 8'hDB, 1'b0);
    total++;
    if ({op1_ksl, op1_wf, op0_wf, op0_fb} !== {2'd3, 1'b1, 1'b1, 3'd3}) begin
      bad++; $display("FAIL reg03 got=%b exp=1111011", {op1_ksl, op1_wf, op0_wf, op0_fb});
    end
    drain();
    snap = dut_vec;
    cycle(1'b1, 1'b0, 8'h39, 1'b0);
    drain();
    cycle(1'b1, 1'b1, 8'hFF, 1'b0);
    drain();
    total++;
    if (dut_vec !== snap) begin bad++; $display("FAIL reg39_noop got=%h exp=%h", dut_vec, snap); end
  endtask

  task automatic test_rhythm();
    logic [5:0] want;
`ifdef YM2413_RHYTHM_EN
    want = 6'h3F;
`else
    want = 6'h00;
`endif
    cycle(1'b1, 1'b0, 8'h0E, 1'b0);
    drain();
    cycle(1'b1, 1'b1, 8'h3F, 1'b0);
    total++;
    if ({rhy_en, rhy_bd, rhy_sd, rhy_tom, rhy_cym, rhy_hh} !== want) begin
      bad++; $display("FAIL rhythm got=%h exp=%h", {rhy_en, rhy_bd, rhy_sd, rhy_tom, rhy_cym, rhy_hh}, want);
    end
    drain();
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 9))
      0, 1:    return 8'($urandom_range(0, 7));
      2:       return 8'h0E;
      3, 4, 5: return 8'($urandom_range(1, 3) * 16 + $urandom_range(0, 8));
      6:       return 8'($urandom_range(8, 15));
      7:       return 8'($urandom_range(9, 15) + 16 * $urandom_range(1, 3));
      8:       return 8'($urandom_range(4, 15) * 16 + $urandom_range(0, 8));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic test_random();
    logic phase_data;
    phase_data = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      if (bcnt == 0 && $urandom_range(0, 3) != 0) begin
        if (phase_data) cycle(1'b1, 1'b1, 8'($urandom), 1'b0);
        else            cycle(1'b1, 1'b0, pick_addr(), 1'b0);
        // Sometimes stay on the data port to rewrite the same register.
        if (!phase_data || $urandom_range(0, 2) == 0) phase_data = ~phase_data;
      end else if ($urandom_range(0, 15) == 0) begin
        cycle(1'b1, 1'($urandom), 8'($urandom), 1'b0);
      end else begin
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
      end
      total++;
      if (busy !== (bcnt != 0)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, bcnt != 0); end
      total++;
      if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rnd_vec c=%0d got=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    drain();
  endtask

  task automatic test_reset_vs_write();
    cycle(1'b1, 1'b0, 8'h38, 1'b0);
    drain();
    cycle(1'b1, 1'b1, 8'hA7, 1'b1);
    total++;
    if ({b_fnum[8], b_block[8], b_sust[8], b_key[8], b_inst[8], b_vol[8]} !== 22'd0) begin
      bad++; $display("FAIL rst_wins_ch8 got=%h exp=0", {b_fnum[8], b_block[8], b_sust[8], b_key[8], b_inst[8], b_vol[8]});
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_wins_busy got=%b exp=0", busy); end
    total++;
    if (dut_vec !== exp_vec()) begin bad++; $display("FAIL rst_wins_vec got=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    lat = 8'h00;
    bcnt = 0;
    test_reset();
    test_block_key();
    test_dropped_write();
    test_patch_and_noop();
    test_rhythm();
    test_random();
    test_reset_vs_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
